// File: rtl/decode_stage_pipe.sv
// MIPS ID stage: IF/ID latch, register file, operand forwarding, branch resolution and ID/EX register.
// Define BRANCH_LINK_EN to decode bltzal/bgezal and drive ex_link_we.
module decode_stage_pipe #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int AW   = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            if_valid,
   input  logic [31:0]     if_instr,
   input  logic [XLEN-1:0] if_pc4,
   input  logic            stall,
   input  logic            flush,
   input  logic            wb_we,
   input  logic [AW-1:0]   wb_addr,
   input  logic [XLEN-1:0] wb_data,
   input  logic [1:0]      fwd_rs_sel,
   input  logic [1:0]      fwd_rt_sel,
   input  logic [XLEN-1:0] fwd_ao,
   input  logic [XLEN-1:0] fwd_pc8,
   output logic            redirect,
   output logic [XLEN-1:0] redirect_pc,
   output logic            eret,
   output logic            ex_valid,
   output logic [31:0]     ex_instr,
   output logic [XLEN-1:0] ex_pc8,
   output logic [XLEN-1:0] ex_d1,
   output logic [XLEN-1:0] ex_d2,
   output logic [XLEN-1:0] ex_ext,
   output logic            ex_link_we
);

   logic            id_valid;
   logic [31:0]     id_instr;
   logic [XLEN-1:0] id_pc4;
   logic [XLEN-1:0] regs [NREG];

   logic [5:0]      op;
   logic [4:0]      rt_field;
   logic [5:0]      funct;
   logic [15:0]     imm;
   logic [AW-1:0]   rs_a;
   logic [AW-1:0]   rt_a;
   logic [XLEN-1:0] rf_rs;
   logic [XLEN-1:0] rf_rt;
   logic [XLEN-1:0] d1;
   logic [XLEN-1:0] d2;
   logic [XLEN-1:0] ext;
   logic [XLEN-1:0] br_target;
   logic [XLEN-1:0] j_target;
   logic            d1_neg;
   logic            d1_zero;
   logic            take;
   logic            is_link;
   logic [XLEN-1:0] target;

   assign op       = id_instr[31:26];
   assign rt_field = id_instr[20:16];
   assign funct    = id_instr[5:0];
   assign imm      = id_instr[15:0];
   assign rs_a     = AW'(id_instr[25:21]);
   assign rt_a     = AW'(id_instr[20:16]);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         id_valid <= 1'b0;
         id_instr <= '0;
         id_pc4   <= '0;
      end else if (flush) begin
         id_valid <= 1'b0;
         id_instr <= '0;
      end else if (!stall) begin
         id_valid <= if_valid;
         id_instr <= if_instr;
         id_pc4   <= if_pc4;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (wb_we && wb_addr != '0) begin
         regs[wb_addr] <= wb_data;
      end
   end

   // Write-back in the same cycle as the read wins, so ID never sees a stale value.
   always_comb begin
      rf_rs = regs[rs_a];
      rf_rt = regs[rt_a];
      if (wb_we && wb_addr == rs_a) rf_rs = wb_data;
      if (wb_we && wb_addr == rt_a) rf_rt = wb_data;
      if (rs_a == '0) rf_rs = '0;
      if (rt_a == '0) rf_rt = '0;
   end

   always_comb begin
      d1 = rf_rs;
      case (fwd_rs_sel)
         2'b00:   d1 = rf_rs;
         2'b01:   d1 = fwd_ao;
         2'b10:   d1 = wb_data;
         default: d1 = fwd_pc8;
      endcase
   end

   always_comb begin
      d2 = rf_rt;
      case (fwd_rt_sel)
         2'b00:   d2 = rf_rt;
         2'b01:   d2 = fwd_ao;
         2'b10:   d2 = wb_data;
         default: d2 = fwd_pc8;
      endcase
   end

   // Logical immediates (andi/ori/xori/lui) are zero-extended.
   assign ext       = (op[5:2] == 4'b0011) ? {{(XLEN-16){1'b0}}, imm}
                                           : {{(XLEN-16){imm[15]}}, imm};
   assign br_target = id_pc4 + {{(XLEN-18){imm[15]}}, imm, 2'b00};
   assign j_target  = {id_pc4[XLEN-1:28], id_instr[25:0], 2'b00};
   assign d1_neg    = d1[XLEN-1];
   assign d1_zero   = (d1 == '0);

   always_comb begin
      take    = 1'b0;
      is_link = 1'b0;
      target  = br_target;
      case (op)
         6'h00: begin
            if (funct == 6'h08 || funct == 6'h09) begin
               take   = 1'b1;
               target = d1;
            end
         end
         6'h01: begin
            case (rt_field)
               5'b00000: take = d1_neg;
               5'b00001: take = !d1_neg;
`ifdef BRANCH_LINK_EN
               5'b10000: begin
                  take    = d1_neg;
                  is_link = 1'b1;
               end
               5'b10001: begin
                  take    = !d1_neg;
                  is_link = 1'b1;
               end
`endif
               default:  take = 1'b0;
            endcase
         end
         6'h02, 6'h03: begin
            take   = 1'b1;
            target = j_target;
         end
         6'h04:   take = (d1 == d2);
         6'h05:   take = (d1 != d2);
         6'h06:   take = d1_neg || d1_zero;
         6'h07:   take = !d1_neg && !d1_zero;
         default: take = 1'b0;
      endcase
   end

   assign redirect    = id_valid && !stall && !flush && take;
   assign redirect_pc = target;
   assign eret        = id_valid && !stall && (id_instr == 32'h4200_0018);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_valid <= 1'b0;
         ex_instr <= '0;
         ex_pc8   <= '0;
         ex_d1    <= '0;
         ex_d2    <= '0;
         ex_ext   <= '0;
      end else if (flush || stall) begin
         ex_valid <= 1'b0;
         ex_instr <= '0;
         ex_pc8   <= '0;
         ex_d1    <= '0;
         ex_d2    <= '0;
         ex_ext   <= '0;
      end else begin
         ex_valid <= id_valid;
         ex_instr <= id_instr;
         ex_pc8   <= id_pc4 + XLEN'(4);
         ex_d1    <= d1;
         ex_d2    <= d2;
         ex_ext   <= ext;
      end
   end

`ifdef BRANCH_LINK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)               ex_link_we <= 1'b0;
      else if (flush || stall) ex_link_we <= 1'b0;
      else                     ex_link_we <= id_valid && is_link && take;
   end
`else
   assign ex_link_we = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe; expectations hand-computed from MIPS encodings.
module tb_decode_stage_pipe;

   localparam int XLEN = 32;
   localparam int AW   = 5;

   logic            clk = 1'b0;
   logic            reset;
   logic            if_valid;
   logic [31:0]     if_instr;
   logic [XLEN-1:0] if_pc4;
   logic            stall;
   logic            flush;
   logic            wb_we;
   logic [AW-1:0]   wb_addr;
   logic [XLEN-1:0] wb_data;
   logic [1:0]      fwd_rs_sel;
   logic [1:0]      fwd_rt_sel;
   logic [XLEN-1:0] fwd_ao;
   logic [XLEN-1:0] fwd_pc8;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   logic            eret;
   logic            ex_valid;
   logic [31:0]     ex_instr;
   logic [XLEN-1:0] ex_pc8;
   logic [XLEN-1:0] ex_d1;
   logic [XLEN-1:0] ex_d2;
   logic [XLEN-1:0] ex_ext;
   logic            ex_link_we;

   int checks   = 0;
   int failures = 0;

   decode_stage_pipe #(.XLEN(XLEN), .NREG(32), .AW(AW)) dut (
      .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc4(if_pc4),
      .stall(stall), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .fwd_ao(fwd_ao), .fwd_pc8(fwd_pc8),
      .redirect(redirect), .redirect_pc(redirect_pc), .eret(eret), .ex_valid(ex_valid),
      .ex_instr(ex_instr), .ex_pc8(ex_pc8), .ex_d1(ex_d1), .ex_d2(ex_d2), .ex_ext(ex_ext),
      .ex_link_we(ex_link_we)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction to fetch for a single edge, then go idle.
   task automatic load(input logic [31:0] instr, input logic [XLEN-1:0] pc4);
      if_valid = 1'b1;
      if_instr = instr;
      if_pc4   = pc4;
      tick();
      if_valid = 1'b0;
      if_instr = '0;
   endtask

   task automatic wb_write(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      wb_we   = 1'b1;
      wb_addr = a;
      wb_data = d;
      tick();
      wb_we   = 1'b0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc4 = '0;
      stall = 1'b0; flush = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
      fwd_rs_sel = 2'b00; fwd_rt_sel = 2'b00; fwd_ao = '0; fwd_pc8 = '0;
      tick();
      tick();
      check("rst_ex_valid", 32'(ex_valid), 32'd0);
      check("rst_ex_instr", ex_instr, 32'd0);
      check("rst_ex_d1", ex_d1, 32'd0);
      check("rst_redirect", 32'(redirect), 32'd0);
      reset = 1'b0;
      tick();

      // addu r1,r5,r0 while r5 is written back in the same cycle
      load(32'h00A0_0821, 32'h40);
      wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
      tick();
      wb_we = 1'b0;
      check("bypass_d1", ex_d1, 32'h1234);
      check("bypass_valid", 32'(ex_valid), 32'd1);
      check("bypass_pc8", ex_pc8, 32'h44);

      // r0 write is dropped, also with a same-cycle write pending
      wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
      load(32'h0000_0821, 32'h50);
      wb_we = 1'b1;
      tick();
      wb_we = 1'b0;
      check("r0_zero", ex_d1, 32'd0);
      load(32'h00A0_0821, 32'h60);
      tick();
      check("rf_hold_r5", ex_d1, 32'h1234);

      // forwarding selects
      load(32'h00A0_0821, 32'h70);
      fwd_rs_sel = 2'b01; fwd_ao = 32'hAAAA_0001;
      fwd_rt_sel = 2'b11; fwd_pc8 = 32'h5555_0002;
      tick();
      check("fwd_ao_d1", ex_d1, 32'hAAAA_0001);
      check("fwd_pc8_d2", ex_d2, 32'h5555_0002);
      load(32'h00A0_0821, 32'h70);
      fwd_rs_sel = 2'b10; wb_data = 32'h0000_BEEF;
      tick();
      check("fwd_wb_d1", ex_d1, 32'h0000_BEEF);
      fwd_rs_sel = 2'b00; fwd_rt_sel = 2'b00;

      // beq r1,r2,+4 at pc4=0x100
      wb_write(5'd1, 32'd7);
      wb_write(5'd2, 32'd7);
      load(32'h1022_0004, 32'h100);
      check("beq_taken", 32'(redirect), 32'd1);
      check("beq_target", redirect_pc, 32'h110);
      wb_we = 1'b1; wb_addr = 5'd2; wb_data = 32'd8;
      #1;
      check("beq_not_taken", 32'(redirect), 32'd0);
      tick();
      wb_we = 1'b0;
      check("beq_ex_d2", ex_d2, 32'd8);

      // bltz r3,-1 at pc4=0x204 -> 0x204 - 4
      wb_write(5'd3, 32'hFFFF_FFFF);
      load(32'h0460_FFFF, 32'h204);
      check("bltz_taken", 32'(redirect), 32'd1);
      check("bltz_target", redirect_pc, 32'h200);
      stall = 1'b1;
      if_valid = 1'b1; if_instr = 32'h00A0_0821; if_pc4 = 32'h300;
      #1;
      check("stall_no_redirect", 32'(redirect), 32'd0);
      tick();
      check("stall_bubble", 32'(ex_valid), 32'd0);
      stall = 1'b0; if_valid = 1'b0; if_instr = '0;
      #1;
      check("stall_held_redirect", 32'(redirect), 32'd1);
      tick();
      check("stall_held_instr", ex_instr, 32'h0460_FFFF);
      load(32'h0460_FFFF, 32'h0);
      check("bltz_wrap", redirect_pc, 32'hFFFF_FFFC);

      // jumps, unknown opcode, eret, immediates
      load(32'h0800_0040, 32'h1000_0008);
      check("j_taken", 32'(redirect), 32'd1);
      check("j_target", redirect_pc, 32'h1000_0100);
      load(32'h0020_0008, 32'h500);
      fwd_rs_sel = 2'b11; fwd_pc8 = 32'h0040_0010;
      #1;
      check("jr_target", redirect_pc, 32'h0040_0010);
      check("jr_taken", 32'(redirect), 32'd1);
      fwd_rs_sel = 2'b00;
      load(32'hFC00_0000, 32'h600);
      check("unk_no_redirect", 32'(redirect), 32'd0);
      tick();
      check("unk_pass_instr", ex_instr, 32'hFC00_0000);
      load(32'h4200_0018, 32'h80);
      check("eret", 32'(eret), 32'd1);
      stall = 1'b1;
      #1;
      check("eret_stalled", 32'(eret), 32'd0);
      stall = 1'b0;
      load(32'h3401_8000, 32'h90);
      tick();
      check("ori_zext", ex_ext, 32'h0000_8000);
      load(32'h2001_8000, 32'h90);
      tick();
      check("addi_sext", ex_ext, 32'hFFFF_8000);

      // flush has priority over stall
      load(32'h00A0_0821, 32'h90);
      flush = 1'b1; stall = 1'b1;
      tick();
      flush = 1'b0; stall = 1'b0;
      check("flush_id_valid", 32'(dut.id_valid), 32'd0);
      check("flush_ex_valid", 32'(ex_valid), 32'd0);

      // asynchronous reset with a jump in ID and a valid EX stage
      if_valid = 1'b1; if_instr = 32'h0800_0040; if_pc4 = 32'h1000_0008;
      tick();
      tick();
      check("pre_rst_ex_valid", 32'(ex_valid), 32'd1);
      check("pre_rst_redirect", 32'(redirect), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("async_rst_ex_valid", 32'(ex_valid), 32'd0);
      check("async_rst_ex_instr", ex_instr, 32'd0);
      check("async_rst_ex_pc8", ex_pc8, 32'd0);
      check("async_rst_redirect", 32'(redirect), 32'd0);
      if_valid = 1'b0; if_instr = '0;
      tick();
      reset = 1'b0;
      tick();
      check("post_rst_redirect", 32'(redirect), 32'd0);

      // bgezal r4 with r4=0 (cleared by reset), pc4=0x400, offset 3 -> 0x40C
      load(32'h0491_0003, 32'h400);
`ifdef BRANCH_LINK_EN
      check("bgezal_redirect", 32'(redirect), 32'd1);
      check("bgezal_target", redirect_pc, 32'h40C);
      tick();
      check("bgezal_link_we", 32'(ex_link_we), 32'd1);
`else
      check("bgezal_redirect", 32'(redirect), 32'd0);
      tick();
      check("bgezal_link_we", 32'(ex_link_we), 32'd0);
`endif
      check("bgezal_ex_valid", 32'(ex_valid), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
